// File: rtl/srsw_rdata_arb_pkg.sv
// Shared definitions for the two-requester RAM read/write arbiter.
package srsw_arb_pkg;

  // Number of requesters on each side (read and write).
  localparam int NUM_REQ = 2;

  // Read response tracker: nothing outstanding, or one response pending.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/srsw_rdata_arb_if.sv
// Requester-side bus of srsw_rdata_arb: read request/response and write request.
// master = requesters, slave = arbiter.
interface srsw_rdata_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  import srsw_arb_pkg::*;

  logic [NUM_REQ-1:0]            rreq_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rreq_addr;
  logic [NUM_REQ-1:0]            rreq_ready;
  logic [NUM_REQ-1:0]            rresp_valid;
  logic [NUM_REQ-1:0]            rresp_ready;
  logic [DATA_WIDTH-1:0]         rresp_data;
  logic [NUM_REQ-1:0]            wreq_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wreq_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wreq_data;
  logic [NUM_REQ-1:0]            wreq_ready;

  modport master (
    output rreq_valid, rreq_addr, rresp_ready, wreq_valid, wreq_addr, wreq_data,
    input  rreq_ready, rresp_valid, rresp_data, wreq_ready
  );

  modport slave (
    input  rreq_valid, rreq_addr, rresp_ready, wreq_valid, wreq_addr, wreq_data,
    output rreq_ready, rresp_valid, rresp_data, wreq_ready
  );

endinterface

// File: rtl/srsw_rdata_arb_rr_arb2.sv
// srsw_rr_arb2: 2-way grant generator. o_cand is the arbitration winner,
// o_gnt is the winner unless i_block vetoes it this cycle. The preference
// pointer only advances on a real grant, so a vetoed winner keeps priority.
// Build option SRSW_ARB_FIXED_PRIO_EN: fixed priority, requester 0 highest,
// no pointer state.
module srsw_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  logic       i_block,
  output logic [1:0] o_cand,
  output logic [1:0] o_gnt
);

`ifdef SRSW_ARB_FIXED_PRIO_EN
  // Fixed priority winner selection, requester 0 first.
  always_comb begin
    o_cand = 2'b00;
    if (!i_en) begin
      o_cand = 2'b00;
    end else if (i_req[0]) begin
      o_cand = 2'b01;
    end else if (i_req[1]) begin
      o_cand = 2'b10;
    end else begin
      o_cand = 2'b00;
    end
  end
`else
  logic r_ptr;

  // Round-robin winner selection starting from the preferred requester.
  always_comb begin
    o_cand = 2'b00;
    if (!i_en) begin
      o_cand = 2'b00;
    end else if (i_req[r_ptr]) begin
      o_cand = r_ptr ? 2'b10 : 2'b01;
    end else if (i_req[~r_ptr]) begin
      o_cand = r_ptr ? 2'b01 : 2'b10;
    end else begin
      o_cand = 2'b00;
    end
  end

  // Pointer moves to the requester that was not just granted; holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (|o_gnt) begin
      r_ptr <= ~o_gnt[1];
    end else begin
      r_ptr <= r_ptr;
    end
  end
`endif

  assign o_gnt = i_block ? 2'b00 : o_cand;

endmodule

// File: rtl/srsw_rdata_arb.sv
// srsw_rdata_arb: arbitrates two readers and two writers onto a single-port
// read / single-port write RAM with one-cycle registered read data. One read
// response may be outstanding; it is held until the owner accepts it.
// Build option SRSW_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module srsw_rdata_arb
  import srsw_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  srsw_rdata_arb_if.slave       bus,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  rsp_state_e            r_state;
  rsp_state_e            w_state_nxt;
  logic                  r_id;
  logic                  w_id_nxt;
  logic [1:0]            w_wcand;
  logic [1:0]            w_wgnt;
  logic [1:0]            w_rcand;
  logic [1:0]            w_rgnt;
  logic                  w_rd_en;
  logic                  w_hazard;
  logic [ADDR_WIDTH-1:0] w_rcand_addr;

  srsw_rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.wreq_valid),
    .i_en    (!rst),
    .i_block (1'b0),
    .o_cand  (w_wcand),
    .o_gnt   (w_wgnt)
  );

  // Drive the RAM write port from the granted writer, zero when idle.
  always_comb begin
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (w_wgnt[0]) begin
      mem_wen   = 1'b1;
      mem_waddr = bus.wreq_addr[ADDR_WIDTH-1:0];
      mem_wdata = bus.wreq_data[DATA_WIDTH-1:0];
    end else if (w_wgnt[1]) begin
      mem_wen   = 1'b1;
      mem_waddr = bus.wreq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      mem_wdata = bus.wreq_data[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      mem_wen   = 1'b0;
    end
  end

  // A read may only issue when no response is pending or the pending one is
  // being accepted this cycle; otherwise mem_rdata must stay frozen.
  assign w_rd_en      = !rst && ((r_state == IDLE) || bus.rresp_ready[r_id]);
  assign w_rcand_addr = w_rcand[1] ? bus.rreq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : bus.rreq_addr[ADDR_WIDTH-1:0];
  // Defer a read that targets the address being written this cycle.
  assign w_hazard     = mem_wen && (|w_rcand) && (w_rcand_addr == mem_waddr);

  srsw_rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.rreq_valid),
    .i_en    (w_rd_en),
    .i_block (w_hazard),
    .o_cand  (w_rcand),
    .o_gnt   (w_rgnt)
  );

  assign mem_ren        = |w_rgnt;
  assign mem_raddr      = mem_ren ? w_rcand_addr : '0;
  assign bus.rreq_ready = w_rgnt;
  assign bus.wreq_ready = w_wgnt;
  assign bus.rresp_data = mem_rdata;

  // Response state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
    end
  end

  // Next response state: a grant always (re)opens PEND, an accept closes it.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    if (|w_rgnt) begin
      w_state_nxt = PEND;
      w_id_nxt    = w_rgnt[1];
    end else if ((r_state == PEND) && bus.rresp_ready[r_id]) begin
      w_state_nxt = IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Response valid follows the pending owner, masked while in reset.
  always_comb begin
    bus.rresp_valid = 2'b00;
    case (r_state)
      PEND:    bus.rresp_valid = rst ? 2'b00 : (r_id ? 2'b10 : 2'b01);
      default: bus.rresp_valid = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_srsw_rdata_arb.sv
// Directed self-checking bench for srsw_rdata_arb with a registered RAM model.
// Honours SRSW_ARB_FIXED_PRIO_EN in its expected grant order.
module tb_srsw_rdata_arb;

`ifdef SRSW_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_wen;
  logic [1:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_ren;
  logic [1:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] ram [0:3];
  int          n_cmp;
  int          n_err;

  srsw_rdata_arb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus ();

  srsw_rdata_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered RAM: read data appears the cycle after mem_ren and holds.
  always @(posedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_raddr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) ram[i] = 32'h0;
    mem_rdata       = 32'h0;
    rst             = 1'b1;
    bus.rreq_valid  = 2'b00;
    bus.rreq_addr   = 4'h0;
    bus.rresp_ready = 2'b00;
    bus.wreq_valid  = 2'b00;
    bus.wreq_addr   = 4'h0;
    bus.wreq_data   = 64'h0;

    // reset, with requests present to show they are blocked
    bus.rreq_valid = 2'b11;
    bus.wreq_valid = 2'b11;
    @(negedge clk);
    chk("rst_rreq_ready", bus.rreq_ready, 2'b00);
    chk("rst_wreq_ready", bus.wreq_ready, 2'b00);
    chk("rst_mem_wen", mem_wen, 1'b0);
    chk("rst_mem_ren", mem_ren, 1'b0);
    chk("rst_rresp_valid", bus.rresp_valid, 2'b00);
    tick();
    rst = 1'b0;
    bus.rreq_valid = 2'b00;

    // two writers contend: 0 then 1
    bus.wreq_valid = 2'b11;
    bus.wreq_addr  = {2'd1, 2'd0};
    bus.wreq_data  = {32'hB, 32'hA};
    @(negedge clk);
    chk("w1_ready", bus.wreq_ready, 2'b01);
    chk("w1_wen", mem_wen, 1'b1);
    chk("w1_waddr", mem_waddr, 2'd0);
    chk("w1_wdata", mem_wdata, 32'hA);
    tick();
    bus.wreq_valid = FIXED ? 2'b10 : 2'b11;
    @(negedge clk);
    chk("w2_ready", bus.wreq_ready, 2'b10);
    chk("w2_waddr", mem_waddr, 2'd1);
    chk("w2_wdata", mem_wdata, 32'hB);
    tick();
    bus.wreq_valid = 2'b00;
    @(negedge clk);
    chk("widle_wen", mem_wen, 1'b0);
    chk("widle_waddr", mem_waddr, 2'd0);
    chk("widle_wdata", mem_wdata, 32'h0);
    tick();

    // back-to-back reads 0,1 by reader 0
    bus.rreq_valid  = 2'b01;
    bus.rreq_addr   = {2'd0, 2'd0};
    bus.rresp_ready = 2'b11;
    @(negedge clk);
    chk("r1_ready", bus.rreq_ready, 2'b01);
    chk("r1_ren", mem_ren, 1'b1);
    chk("r1_raddr", mem_raddr, 2'd0);
    chk("r1_rvalid", bus.rresp_valid, 2'b00);
    tick();
    bus.rreq_addr = {2'd0, 2'd1};
    @(negedge clk);
    chk("r2_rvalid", bus.rresp_valid, 2'b01);
    chk("r2_data", bus.rresp_data, 32'hA);
    chk("r2_ready", bus.rreq_ready, 2'b01);
    chk("r2_raddr", mem_raddr, 2'd1);
    tick();
    bus.rreq_valid = 2'b00;
    @(negedge clk);
    chk("r3_rvalid", bus.rresp_valid, 2'b01);
    chk("r3_data", bus.rresp_data, 32'hB);
    chk("r3_ren", mem_ren, 1'b0);
    chk("r3_raddr", mem_raddr, 2'd0);
    tick();
    @(negedge clk);
    chk("r4_rvalid", bus.rresp_valid, 2'b00);
    tick();

    // response held while the owner is not ready
    bus.rreq_valid  = 2'b01;
    bus.rreq_addr   = {2'd0, 2'd0};
    bus.rresp_ready = 2'b00;
    @(negedge clk);
    chk("h0_ready", bus.rreq_ready, 2'b01);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("h_rvalid", bus.rresp_valid, 2'b01);
      chk("h_data", bus.rresp_data, 32'hA);
      chk("h_ren", mem_ren, 1'b0);
      chk("h_ready", bus.rreq_ready, 2'b00);
      tick();
    end
    bus.rresp_ready = 2'b01;
    @(negedge clk);
    chk("h4_ready", bus.rreq_ready, 2'b01);
    chk("h4_ren", mem_ren, 1'b1);
    chk("h4_rvalid", bus.rresp_valid, 2'b01);
    tick();
    bus.rreq_valid = 2'b00;
    @(negedge clk);
    chk("h5_rvalid", bus.rresp_valid, 2'b01);
    chk("h5_data", bus.rresp_data, 32'hA);
    tick();
    @(negedge clk);
    chk("h6_rvalid", bus.rresp_valid, 2'b00);
    tick();

    // read/write to the same address in the same cycle
    bus.wreq_valid  = 2'b01;
    bus.wreq_addr   = {2'd0, 2'd2};
    bus.wreq_data   = {32'h0, 32'hC};
    bus.rreq_valid  = 2'b01;
    bus.rreq_addr   = {2'd0, 2'd2};
    bus.rresp_ready = 2'b11;
    @(negedge clk);
    chk("z0_wready", bus.wreq_ready, 2'b01);
    chk("z0_rready", bus.rreq_ready, 2'b00);
    chk("z0_ren", mem_ren, 1'b0);
    tick();
    bus.wreq_valid = 2'b00;
    @(negedge clk);
    chk("z1_rready", bus.rreq_ready, 2'b01);
    chk("z1_raddr", mem_raddr, 2'd2);
    tick();
    bus.rreq_valid = 2'b00;
    @(negedge clk);
    chk("z2_rvalid", bus.rresp_valid, 2'b01);
    chk("z2_data", bus.rresp_data, 32'hC);
    tick();

    // both readers: reader 1 wants addr 0, reader 0 wants addr 1
    bus.rreq_valid = 2'b11;
    bus.rreq_addr  = {2'd0, 2'd1};
    @(negedge clk);
    chk("b0_ready", bus.rreq_ready, FIXED ? 2'b01 : 2'b10);
    chk("b0_raddr", mem_raddr, FIXED ? 2'd1 : 2'd0);
    tick();
    @(negedge clk);
    chk("b1_ready", bus.rreq_ready, 2'b01);
    chk("b1_rvalid", bus.rresp_valid, FIXED ? 2'b01 : 2'b10);
    chk("b1_data", bus.rresp_data, FIXED ? 32'hB : 32'hA);
    tick();
    bus.rreq_valid = 2'b00;
    @(negedge clk);
    chk("b2_rvalid", bus.rresp_valid, 2'b01);
    chk("b2_data", bus.rresp_data, 32'hB);
    tick();

    // reset while a response is pending
    bus.rreq_valid  = 2'b01;
    bus.rreq_addr   = {2'd0, 2'd1};
    bus.rresp_ready = 2'b00;
    @(negedge clk);
    chk("p0_ready", bus.rreq_ready, 2'b01);
    tick();
    bus.rreq_valid = 2'b00;
    @(negedge clk);
    chk("p1_rvalid", bus.rresp_valid, 2'b01);
    chk("p1_data", bus.rresp_data, 32'hB);
    tick();
    rst = 1'b1;
    bus.rreq_valid = 2'b01;
    @(negedge clk);
    chk("p2_rvalid", bus.rresp_valid, 2'b00);
    chk("p2_rready", bus.rreq_ready, 2'b00);
    chk("p2_ren", mem_ren, 1'b0);
    tick();
    rst = 1'b0;
    bus.rreq_addr   = {2'd0, 2'd0};
    bus.rresp_ready = 2'b11;
    @(negedge clk);
    chk("p3_rvalid", bus.rresp_valid, 2'b00);
    chk("p3_ready", bus.rreq_ready, 2'b01);
    tick();
    bus.rreq_valid = 2'b00;
    @(negedge clk);
    chk("p4_rvalid", bus.rresp_valid, 2'b01);
    chk("p4_data", bus.rresp_data, 32'hA);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
